// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer and the ALU it drives: opcode encoding,
// sequencer state encoding and default datapath dimensions.
package alu_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREGS  = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_OR  = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_LD  = 3'd6,
    OP_ST  = 3'b111
  } op_code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file with an internal store port that beats the
// external preload port on an index collision, and two combinational reads.
module alu_regfile import alu_seq_pkg::*; #(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_we_i,
  input  logic [SEL_W-1:0]  st_sel_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              ext_we_i,
  input  logic [SEL_W-1:0]  ext_sel_i,
  input  logic [DATA_W-1:0] ext_data_i,
  input  logic [SEL_W-1:0]  opnd_sel_i,
  output logic [DATA_W-1:0] opnd_data_o,
  input  logic [SEL_W-1:0]  dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    // NOTE: regs_d starts as a copy of regs_q so every path assigns it and no latch is inferred.
    regs_d = regs_q;
    if (ext_we_i) regs_d[ext_sel_i] = ext_data_i;
    // Applied second so a store to the same index overrides the preload.
    if (st_we_i)  regs_d[st_sel_i]  = st_data_i;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: this small file must come up zeroed, so it is reset like ordinary flops; <= keeps edge semantics.
    if (rst_i) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign opnd_data_o = regs_q[opnd_sel_i];
  assign dbg_data_o  = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Front end for the 8-bit combinational ALU: accepts one instruction per
// handshake, drives the ALU for one cycle and writes the result back into A/CY.
module alu_sequencer import alu_seq_pkg::*; #(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic              IN_CLK,
  input  logic              IN_RST,
  input  logic              IN_INSTR_VALID,
  output logic              OUT_INSTR_READY,
  input  logic [2:0]        IN_OPCODE,
  input  logic [SEL_W-1:0]  IN_REG_SEL,
  input  logic              IN_WR_EN,
  input  logic [SEL_W-1:0]  IN_WR_SEL,
  input  logic [DATA_W-1:0] IN_WR_DATA,
  input  logic [SEL_W-1:0]  IN_RD_SEL,
  output logic [DATA_W-1:0] OUT_RD_DATA,
  output logic [DATA_W-1:0] OUT_ALU_A,
  output logic [DATA_W-1:0] OUT_ALU_R,
  output logic [2:0]        OUT_ALU_OP,
  input  logic [DATA_W-1:0] IN_ALU_RES,
  input  logic              IN_ALU_CY,
  output logic [DATA_W-1:0] OUT_A,
  output logic              OUT_CY,
  output logic              OUT_DONE
);

  seq_state_t        state_q, state_d;
  op_code_t          op_q, op_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              cy_q, cy_d;
  logic              st_we;
  logic              accept;
  logic [DATA_W-1:0] rf_opnd;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk_i       (IN_CLK),
    .rst_i       (IN_RST),
    .st_we_i     (st_we),
    .st_sel_i    (sel_q),
    .st_data_i   (a_q),
    .ext_we_i    (IN_WR_EN),
    .ext_sel_i   (IN_WR_SEL),
    .ext_data_i  (IN_WR_DATA),
    .opnd_sel_i  (IN_REG_SEL),
    .opnd_data_o (rf_opnd),
    .dbg_sel_i   (IN_RD_SEL),
    .dbg_data_o  (OUT_RD_DATA)
  );

  assign OUT_INSTR_READY = (state_q == S_IDLE) && !IN_RST;
  assign accept          = IN_INSTR_VALID && OUT_INSTR_READY;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    cy_d    = cy_q;
    st_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_code_t'(IN_OPCODE);
          sel_d   = IN_REG_SEL;
          opnd_d  = rf_opnd;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            a_d  = IN_ALU_RES;
            cy_d = IN_ALU_CY;
          end
          OP_OR, OP_AND, OP_XOR, OP_NOT: begin
            a_d  = IN_ALU_RES;
            cy_d = 1'b0;
          end
          OP_LD:   a_d   = IN_ALU_RES;
          OP_ST:   st_we = 1'b1;
          default: ;
        endcase
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLK) begin
    if (IN_RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_LD;
      sel_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      cy_q    <= cy_d;
    end
  end

  // The ALU has no store operation; during ST it just passes the operand through.
  assign OUT_ALU_OP = (op_q == OP_ST) ? OP_LD : op_q;
  assign OUT_ALU_A  = a_q;
  assign OUT_ALU_R  = opnd_q;
  assign OUT_A      = a_q;
  assign OUT_CY     = cy_q;
  assign OUT_DONE   = (state_q == S_DONE) && !IN_RST;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: alu_sequencer driving a behavioural 8-bit ALU, with
// directed vectors, multi-cycle corner cases and a randomized model check.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [2:0] opcode;
  logic [1:0] reg_sel;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_r;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_cy;
  logic [7:0] acc;
  logic       cy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  int ref_a;
  int ref_cy;
  int ref_r [4];

  typedef struct {
    logic       pre_en;
    logic [1:0] pre_sel;
    logic [7:0] pre_data;
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] exp_a;
    logic       exp_cy;
  } vec_t;

  vec_t vecs [6];

  alu_sequencer dut (
    .IN_CLK          (clk),
    .IN_RST          (rst),
    .IN_INSTR_VALID  (valid),
    .OUT_INSTR_READY (ready),
    .IN_OPCODE       (opcode),
    .IN_REG_SEL      (reg_sel),
    .IN_WR_EN        (wr_en),
    .IN_WR_SEL       (wr_sel),
    .IN_WR_DATA      (wr_data),
    .IN_RD_SEL       (rd_sel),
    .OUT_RD_DATA     (rd_data),
    .OUT_ALU_A       (alu_a),
    .OUT_ALU_R       (alu_r),
    .OUT_ALU_OP      (alu_op),
    .IN_ALU_RES      (alu_res),
    .IN_ALU_CY       (alu_cy),
    .OUT_A           (acc),
    .OUT_CY          (cy),
    .OUT_DONE        (done)
  );

  // Behavioural ALU: 9-bit add/subtract, bitwise ops, NOT of A, LD passes R.
  logic [8:0] sum9;
  logic [8:0] diff9;
  assign sum9  = {1'b0, alu_a} + {1'b0, alu_r};
  assign diff9 = {1'b0, alu_a} - {1'b0, alu_r};

  always_comb begin
    alu_res = alu_r;
    alu_cy  = 1'b0;
    case (alu_op)
      3'd0: {alu_cy, alu_res} = sum9;
      3'd1: {alu_cy, alu_res} = diff9;
      3'd2: alu_res = alu_a | alu_r;
      3'd3: alu_res = alu_a & alu_r;
      3'd4: alu_res = alu_a ^ alu_r;
      3'd5: alu_res = ~alu_a;
      default: alu_res = alu_r;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_a  = 0;
    ref_cy = 0;
    for (int i = 0; i < 4; i++) ref_r[i] = 0;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [1:0] sel);
    int r;
    int s;
    r = ref_r[sel];
    case (op)
      3'd0: begin
        s      = ref_a + r;
        ref_cy = (s > 255) ? 1 : 0;
        ref_a  = s % 256;
      end
      3'd1: begin
        ref_cy = (ref_a < r) ? 1 : 0;
        ref_a  = (ref_a + 256 - r) % 256;
      end
      3'd2: begin ref_a = ref_a | r; ref_cy = 0; end
      3'd3: begin ref_a = ref_a & r; ref_cy = 0; end
      3'd4: begin ref_a = ref_a ^ r; ref_cy = 0; end
      3'd5: begin ref_a = 255 - ref_a; ref_cy = 0; end
      3'd6: ref_a = r;
      default: ref_r[sel] = ref_a;
    endcase
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && ready !== 1'b1; i++) @(negedge clk);
    check("ready_wait", ready, 1);
  endtask

  task automatic preload(input logic [1:0] sel, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    ref_r[sel] = data;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check(name, rd_data, ref_r[i]);
    end
  endtask

  // Issues one instruction, holding VALID through EXEC and DONE to show it is not re-accepted.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] sel);
    valid   = 1'b1;
    opcode  = op;
    reg_sel = sel;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    check("ready_in_exec", ready, 0);
    check("done_in_exec", done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("ready_in_done", ready, 0);
    valid = 1'b0;
    model_exec(op, sel);
    check("acc", acc, ref_a);
    check("carry", cy, ref_cy);
    @(negedge clk);
    check("done_clear", done, 0);
    check("acc_no_reaccept", acc, ref_a);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd1, 8'hF0, 3'd6, 2'd1, 8'hF0, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 8'h20, 3'd0, 2'd2, 8'h10, 1'b1};
    vecs[2] = '{1'b1, 2'd2, 8'h05, 3'd6, 2'd2, 8'h05, 1'b1};
    vecs[3] = '{1'b1, 2'd0, 8'h06, 3'd1, 2'd0, 8'hFF, 1'b1};
    vecs[4] = '{1'b1, 2'd3, 8'h0F, 3'd3, 2'd3, 8'h0F, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 3'd6, 2'd3, 8'h0F, 1'b0};

    rst = 1'b1; valid = 1'b0; opcode = 3'd0; reg_sel = 2'd0;
    wr_en = 1'b0; wr_sel = 2'd0; wr_data = 8'd0; rd_sel = 2'd0;
    model_reset();

    // Reset held for two cycles
    @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", ready, 0);
    @(negedge clk);
    check("ready_in_reset2", ready, 0);
    check("done_in_reset", done, 0);
    check("acc_reset", acc, 0);
    check("carry_reset", cy, 0);
    check_regs("regs_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", ready, 1);
    @(negedge clk);

    // Directed vectors: preload, LD/ADD wrap with carry, SUB borrow, AND clears carry, LD keeps carry
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_en) preload(vecs[i].pre_sel, vecs[i].pre_data);
      run_instr(vecs[i].op, vecs[i].sel);
      check($sformatf("vec%0d_acc", i), acc, vecs[i].exp_a);
      check($sformatf("vec%0d_carry", i), cy, vecs[i].exp_cy);
    end

    // ST collides with a preload to the same index on the writeback edge
    preload(2'd1, 8'h5A);
    run_instr(3'd6, 2'd1);
    valid = 1'b1; opcode = 3'd7; reg_sel = 2'd0;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("st_done", done, 1);
    model_exec(3'd7, 2'd0);
    check("st_acc", acc, 8'h5A);
    check("st_carry", cy, 0);
    check_regs("st_regs");
    rd_sel = 2'd0;
    #1;
    check("st_wins", rd_data, 8'h5A);
    @(negedge clk);

    // Preload during EXEC must not change the latched operand
    preload(2'd1, 8'h01);
    run_instr(3'd6, 2'd1);
    valid = 1'b1; opcode = 3'd0; reg_sel = 2'd1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h80;
    @(negedge clk);
    wr_en = 1'b0;
    check("latch_done", done, 1);
    check("latch_acc", acc, 8'h02);
    check("latch_carry", cy, 0);
    ref_a = 2; ref_cy = 0; ref_r[1] = 8'h80;
    check_regs("latch_regs");
    @(negedge clk);

    // Reset during EXEC aborts the instruction
    valid = 1'b1; opcode = 3'd0; reg_sel = 2'd1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", done, 0);
    check("abort_acc", acc, 0);
    check("abort_carry", cy, 0);
    rst = 1'b0;
    #1;
    check("abort_idle_ready", ready, 1);
    model_reset();
    check_regs("abort_regs");
    @(negedge clk);
    check("abort_no_late_done", done, 0);
    preload(2'd2, 8'h33);
    run_instr(3'd6, 2'd2);
    check("post_abort_acc", acc, 8'h33);

    // Randomized instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(1, 0) == 1) preload(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
      run_instr(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)));
      if (n % 10 == 9) begin
        check_regs("rand_regs");
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
